mmio_uart_buffer: RTL and testbench
===================================

# mmio_uart_buffer

Memory-mapped, FIFO-buffered UART front end sitting between the CPU data port (`dcache_addr`/`dcache_we`/`dcache_re`/`dcache_din`) and the existing byte-wide UART handshake (`DataIn`/`DataInValid`/`DataInReady`, `DataOut`/`DataOutValid`/`DataOutReady`). It replaces the single-byte UART control path with parametrised-depth TX/RX FIFOs, fill-level status, sticky error flags and a maskable interrupt, so software can burst bytes without polling per character.

## Interface
- `ADDR_BASE`, 32'h8000_0000, base of the 16-byte register window; bits [3:0] must be 0.
- `TX_DEPTH`, 8, TX FIFO entries; power of two, 2..128.
- `RX_DEPTH`, 8, RX FIFO entries; power of two, 2..128.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to `clk` at system level.
- `stall`  in  1  CPU stall; while high, `re`/`we` are ignored.
- `addr`  in  32  byte address from CPU.
- `we`  in  4  byte write enables.
- `re`  in  1  read enable.
- `din`  in  32  write data.
- `dout`  out  32  registered read data.
- `uart_tx_data`  out  8  byte to UART transmitter.
- `uart_tx_valid`  out  1  TX FIFO non-empty.
- `uart_tx_ready`  in  1  transmitter accepts byte.
- `uart_rx_data`  in  8  byte from UART receiver.
- `uart_rx_valid`  in  1  receiver has byte.
- `uart_rx_ready`  out  1  RX FIFO not full.
- `irq`  out  1  registered interrupt request.

## Operation
- Hit: `addr[31:4] == ADDR_BASE[31:4]` and `stall == 0`. Register selected by `addr[3:2]`. Misses: no side effects; a read miss loads `dout` with 0.
- 0x0 STATUS (R): [0] tx_not_full, [1] rx_not_empty, [2] rx_overflow, [3] tx_empty, [4] tx_drop, [15:8] rx_count, [23:16] tx_count; rest 0. Write with `we != 0`: `din[2]=1` clears rx_overflow, `din[4]=1` clears tx_drop.
- 0x4 RX_DATA (R): returns {24'b0, head byte} and pops. If empty: returns 0, no pop. Writes ignored.
- 0x8 TX_DATA (W, needs `we[0]`): pushes `din[7:0]`. If full and no TX pop this cycle: byte discarded, tx_drop set. Reads return 0.
- 0xC IRQ_EN (R/W, needs `we[0]`): [0] rx_ie, [1] tx_ie.
- TX drain: `uart_tx_valid = !tx_empty`, `uart_tx_data` = TX head; pop on `uart_tx_valid && uart_tx_ready`.
- RX fill: `uart_rx_ready = !rx_full`; push on `uart_rx_valid && uart_rx_ready`. `uart_rx_valid && rx_full` sets rx_overflow; the receiver drops that byte.
- `irq` next = (rx_ie & rx_not_empty) | (tx_ie & tx_empty) | rx_overflow | tx_drop.
- FIFOs: circular, pointers wrap modulo depth, count width log2(depth)+1, zero-extended into the 8-bit status fields.
- Sticky set and software clear in the same cycle: set wins.

## Timing
- Reset (rst low): FIFOs empty, pointers 0, stickies 0, IRQ_EN 0, `dout`=0, `irq`=0, `uart_tx_valid`=0, `uart_tx_data`=0, `uart_rx_ready`=1. Reset mid-transfer discards all FIFO contents immediately.
- Read latency 1: `dout` valid on the cycle after a hit with `re`; `dout` holds when no read or `stall` is high.
- A pop from RX_DATA happens on the same edge that captures `dout`; the STATUS read in the next cycle shows the decremented count.
- TX push at edge N: `uart_tx_valid` high after edge N (empty FIFO case), so data is visible in cycle N+1.
- TX full + CPU push + UART pop in the same cycle: push accepted, count unchanged, no tx_drop.
- RX empty + CPU pop + UART push in the same cycle: read returns 0, byte stored, count becomes 1.
- RX full + CPU pop in the same cycle as `uart_rx_valid`: `uart_rx_ready` was low, so no push and overflow is set. `uart_rx_ready` returns high next cycle.
- `irq` lags its causes by exactly 1 cycle.

## Test plan
- Reset: drive rst low mid-burst with TX holding 3 bytes → `uart_tx_valid`=0, `uart_rx_ready`=1, STATUS read after release = 0x0000_0009.
- TX burst: write 0x41..0x48 to 0x8000_0008 with `uart_tx_ready`=0 → STATUS tx_count=8, tx_not_full=0. Write 0x49 → tx_drop=1. Raise ready → bytes 0x41..0x48 emitted in order, one per cycle.
- RX path: push 0x55 and 0xAA on the UART side → read 0x8000_0004 twice returns 0x55 then 0xAA (1-cycle latency). A third read returns 0 and count stays 0.
- RX overflow: fill 8 bytes and keep `uart_rx_valid` high → `uart_rx_ready`=0, rx_overflow=1, `irq`=1. Write STATUS `din`=0x4 → flag cleared, `irq` low next cycle.
- Simultaneous ops: TX full + CPU push + `uart_tx_ready` high in the same cycle → tx_count stays 8, no drop, pushed byte emitted last.
- Stall/IRQ: write IRQ_EN=0x2 with `stall`=1 → no effect. Repeat with `stall`=0 and TX empty → `irq`=1 one cycle later.

Source files
------------

// File: rtl/mmio_uart_buffer.sv
// Memory-mapped UART front end: CPU register window over TX/RX byte FIFOs,
// with fill-level status, sticky error flags and a registered interrupt.
`timescale 1ns/1ps

module uart_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               pushData,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign head  = mem[rdPtr];

  // Depth is a power of two, so pointers wrap for free. The caller only pushes
  // a full FIFO when it pops on the same edge, which leaves count unchanged.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_ONE;
      if (pop)  rdPtr <= rdPtr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers define validity,
  // and leaving the array out of reset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushData;
  end
endmodule

module mmio_uart_buffer #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] addr,
  input  logic [3:0]  we,
  input  logic        re,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic        irq
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_RX_DATA = 2'd1,
    REG_TX_DATA = 2'd2,
    REG_IRQ_EN  = 2'd3
  } reg_sel_e;

  reg_sel_e      regSel;
  logic          hit;
  logic          rdHit;
  logic          wrHit;
  logic          wrByte0;
  logic          statusClr;

  logic [7:0]    txHead;
  logic [TX_AW:0] txCount;
  logic          txEmpty;
  logic          txFull;
  logic          txPushReq;
  logic          txPush;
  logic          txPop;
  logic          txDropSet;

  logic [7:0]    rxHead;
  logic [RX_AW:0] rxCount;
  logic          rxEmpty;
  logic          rxFull;
  logic          rxPush;
  logic          rxPop;
  logic          rxOverflowSet;

  logic          rxOverflow;
  logic          txDrop;
  logic [1:0]    irqEn;
  logic [31:0]   statusWord;
  logic [31:0]   readData;
  logic          unusedBits;

  assign unusedBits = ^{addr[1:0], din[31:8]};

  // Decode: stall masks every CPU-side side effect, including read data capture.
  assign regSel    = reg_sel_e'(addr[3:2]);
  assign hit       = !stall && (addr[31:4] == ADDR_BASE[31:4]);
  assign rdHit     = hit && re;
  assign wrHit     = hit && (we != 4'h0);
  assign wrByte0   = hit && we[0];
  assign statusClr = wrHit && (regSel == REG_STATUS);

  // A push into a full TX FIFO is still accepted when the transmitter drains
  // the head on the same edge.
  assign txPop     = !txEmpty && uart_tx_ready;
  assign txPushReq = wrByte0 && (regSel == REG_TX_DATA);
  assign txPush    = txPushReq && (!txFull || txPop);
  assign txDropSet = txPushReq && txFull && !txPop;

  // rx_ready reflects the pre-edge fill level, so a CPU pop cannot make room
  // for a byte arriving on the same edge; that byte counts as an overflow.
  assign rxPush        = uart_rx_valid && !rxFull;
  assign rxOverflowSet = uart_rx_valid && rxFull;
  assign rxPop         = rdHit && (regSel == REG_RX_DATA) && !rxEmpty;

  uart_byte_fifo #(.DEPTH(TX_DEPTH)) txFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (txPush),
    .pushData (din[7:0]),
    .pop      (txPop),
    .head     (txHead),
    .count    (txCount),
    .empty    (txEmpty),
    .full     (txFull)
  );

  uart_byte_fifo #(.DEPTH(RX_DEPTH)) rxFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rxPush),
    .pushData (uart_rx_data),
    .pop      (rxPop),
    .head     (rxHead),
    .count    (rxCount),
    .empty    (rxEmpty),
    .full     (rxFull)
  );

  assign uart_tx_valid = !txEmpty;
  assign uart_tx_data  = txEmpty ? 8'h00 : txHead;
  assign uart_rx_ready = !rxFull;

  assign statusWord = {8'h00, 8'(txCount), 8'(rxCount), 3'b000,
                       txDrop, txEmpty, rxOverflow, !rxEmpty, !txFull};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    readData = '0;
    case (regSel)
      REG_STATUS:  readData = statusWord;
      REG_RX_DATA: if (!rxEmpty) readData = {24'h0, rxHead};
      REG_TX_DATA: readData = '0;
      REG_IRQ_EN:  readData = {30'h0, irqEn};
      default:     readData = '0;
    endcase
  end

  // Read data is registered; a read miss returns zero, a stalled cycle holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
    end else if (re && !stall) begin
      dout <= hit ? readData : '0;
    end
  end

  // Stickies: a hardware set on the same edge as a software clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxOverflow <= 1'b0;
      txDrop     <= 1'b0;
      irqEn      <= 2'b00;
      irq        <= 1'b0;
    end else begin
      rxOverflow <= rxOverflowSet || (rxOverflow && !(statusClr && din[2]));
      txDrop     <= txDropSet || (txDrop && !(statusClr && din[4]));
      if (wrByte0 && (regSel == REG_IRQ_EN)) irqEn <= din[1:0];
      irq <= (irqEn[0] && !rxEmpty) || (irqEn[1] && txEmpty) || rxOverflow || txDrop;
    end
  end
endmodule

// File: tb/tb_mmio_uart_buffer.sv
// Self-checking bench for mmio_uart_buffer: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps

module tb_mmio_uart_buffer;
  localparam int          TXD      = 8;
  localparam int          RXD      = 8;
  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam logic [31:0] A_STATUS = 32'h8000_0000;
  localparam logic [31:0] A_RX     = 32'h8000_0004;
  localparam logic [31:0] A_TX     = 32'h8000_0008;
  localparam logic [31:0] A_IE     = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [3:0]  we = 4'h0;
  logic        re = 1'b0;
  logic [31:0] din = 32'h0;
  logic [31:0] dout;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady = 1'b0;
  logic [7:0]  rxData = 8'h0;
  logic        rxValid = 1'b0;
  logic        rxReady;
  logic        irq;

  int nTests = 0;
  int nFail  = 0;

  mmio_uart_buffer #(.ADDR_BASE(BASE), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .addr          (addr),
    .we            (we),
    .re            (re),
    .din           (din),
    .dout          (dout),
    .uart_tx_data  (txData),
    .uart_tx_valid (txValid),
    .uart_tx_ready (txReady),
    .uart_rx_data  (rxData),
    .uart_rx_valid (rxValid),
    .uart_rx_ready (rxReady),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  // Reference model: FIFOs as queues, registers as plain variables.
  logic [7:0]  mTx[$];
  logic [7:0]  mRx[$];
  logic        mOvf;
  logic        mDrop;
  logic        mIrq;
  logic [1:0]  mIe;
  logic [31:0] mDout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mTx.delete();
    mRx.delete();
    mOvf  = 1'b0;
    mDrop = 1'b0;
    mIrq  = 1'b0;
    mIe   = 2'b00;
    mDout = 32'h0;
  endtask

  function automatic logic [31:0] mStatus();
    logic [31:0] s;
    s        = 32'h0;
    s[0]     = (mTx.size() < TXD);
    s[1]     = (mRx.size() != 0);
    s[2]     = mOvf;
    s[3]     = (mTx.size() == 0);
    s[4]     = mDrop;
    s[15:8]  = 8'(mRx.size());
    s[23:16] = 8'(mTx.size());
    return s;
  endfunction

  // One clock edge of the specified behaviour, evaluated from pre-edge state.
  task automatic modelStep();
    logic        hit;
    logic        txPop;
    logic        txFullB;
    logic        rxFullB;
    logic        irqN;
    logic [1:0]  sel;
    logic [31:0] rd;
    hit  = !stall && ((addr & 32'hFFFF_FFF0) == BASE);
    sel  = addr[3:2];
    irqN = (mIe[0] && mRx.size() != 0) || (mIe[1] && mTx.size() == 0) || mOvf || mDrop;
    rd   = 32'h0;
    if (sel == 2'd0) rd = mStatus();
    if (sel == 2'd1 && mRx.size() != 0) rd = {24'h0, mRx[0]};
    if (sel == 2'd3) rd = {30'h0, mIe};
    if (re && !stall) mDout = hit ? rd : 32'h0;
    txFullB = (mTx.size() == TXD);
    rxFullB = (mRx.size() == RXD);
    txPop   = (mTx.size() != 0) && txReady;
    if (hit && we != 4'h0 && sel == 2'd0) begin
      if (din[2]) mOvf = 1'b0;
      if (din[4]) mDrop = 1'b0;
    end
    if (txPop) void'(mTx.pop_front());
    if (hit && we[0] && sel == 2'd2) begin
      if (txFullB && !txPop) mDrop = 1'b1;
      else mTx.push_back(din[7:0]);
    end
    if (hit && re && sel == 2'd1 && mRx.size() != 0) void'(mRx.pop_front());
    if (rxValid) begin
      if (rxFullB) mOvf = 1'b1;
      else mRx.push_back(rxData);
    end
    if (hit && we[0] && sel == 2'd3) mIe = din[1:0];
    mIrq = irqN;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    check("dout", dout, mDout);
    check("irq", 32'(irq), 32'(mIrq));
    check("tx_valid", 32'(txValid), 32'(mTx.size() != 0));
    check("tx_data", 32'(txData), (mTx.size() != 0) ? 32'(mTx[0]) : 32'h0);
    check("rx_ready", 32'(rxReady), 32'(mRx.size() < RXD));
  endtask

  task automatic idle();
    stall = 1'b0; we = 4'h0; re = 1'b0; din = 32'h0;
    txReady = 1'b0; rxValid = 1'b0; rxData = 8'h0;
  endtask

  task automatic cpuWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    addr = a; din = d; we = w; re = 1'b0;
    tick();
    we = 4'h0;
  endtask

  task automatic cpuRead(input logic [31:0] a);
    addr = a; re = 1'b1; we = 4'h0;
    tick();
    re = 1'b0;
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic        re;
    logic [31:0] din;
    logic        txRdy;
    logic        rxV;
    logic [7:0]  rxD;
    logic [31:0] expDout;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic [3:0] w, input logic r,
                              input logic [31:0] d, input logic t, input logic v,
                              input logic [7:0] x, input logic [31:0] e);
    mk = '{a, w, r, d, t, v, x, e};
  endfunction

  vec_t tbl [33];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] expTx [8];

    // TX burst into a stalled transmitter, overfill, drain, clear drop.
    for (int i = 0; i < 8; i++)
      tbl[i] = mk(A_TX, 4'h1, 1'b0, 32'h41 + 32'(i), 1'b0, 1'b0, 8'h00, 32'h0);
    tbl[8]  = mk(A_STATUS, 4'h0, 1'b1, 32'h0,  1'b0, 1'b0, 8'h00, 32'h0008_0000);
    tbl[9]  = mk(A_TX,     4'h1, 1'b0, 32'h49, 1'b0, 1'b0, 8'h00, 32'h0008_0000);
    tbl[10] = mk(A_STATUS, 4'h0, 1'b1, 32'h0,  1'b0, 1'b0, 8'h00, 32'h0008_0010);
    for (int i = 11; i < 19; i++)
      tbl[i] = mk(A_STATUS, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 32'h0008_0010);
    tbl[19] = mk(A_STATUS, 4'h0, 1'b1, 32'h0,  1'b0, 1'b0, 8'h00, 32'h0000_0019);
    tbl[20] = mk(A_STATUS, 4'hF, 1'b0, 32'h10, 1'b0, 1'b0, 8'h00, 32'h0000_0019);
    tbl[21] = mk(A_STATUS, 4'h0, 1'b1, 32'h0,  1'b0, 1'b0, 8'h00, 32'h0000_0009);
    // RX path: two bytes in, read back in order, then an empty read.
    tbl[22] = mk(A_STATUS, 4'h0, 1'b0, 32'h0,  1'b0, 1'b1, 8'h55, 32'h0000_0009);
    tbl[23] = mk(A_STATUS, 4'h0, 1'b0, 32'h0,  1'b0, 1'b1, 8'hAA, 32'h0000_0009);
    tbl[24] = mk(A_STATUS, 4'h0, 1'b1, 32'h0,  1'b0, 1'b0, 8'h00, 32'h0000_020B);
    tbl[25] = mk(A_RX,     4'h0, 1'b1, 32'h0,  1'b0, 1'b0, 8'h00, 32'h0000_0055);
    tbl[26] = mk(A_RX,     4'h0, 1'b1, 32'h0,  1'b0, 1'b0, 8'h00, 32'h0000_00AA);
    tbl[27] = mk(A_RX,     4'h0, 1'b1, 32'h0,  1'b0, 1'b0, 8'h00, 32'h0000_0000);
    tbl[28] = mk(A_STATUS, 4'h0, 1'b1, 32'h0,  1'b0, 1'b0, 8'h00, 32'h0000_0009);
    tbl[29] = mk(A_IE,     4'h1, 1'b0, 32'h3,  1'b0, 1'b0, 8'h00, 32'h0000_0009);
    tbl[30] = mk(A_IE,     4'h0, 1'b1, 32'h0,  1'b0, 1'b0, 8'h00, 32'h0000_0003);
    tbl[31] = mk(32'h8000_0010, 4'h0, 1'b1, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0000_0000);
    tbl[32] = mk(A_IE,     4'h1, 1'b0, 32'h0,  1'b0, 1'b0, 8'h00, 32'h0000_0000);

    // Power-on reset.
    modelReset();
    #2 rst = 1'b0;
    #1;
    check("reset dout", dout, 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    check("reset tx_valid", 32'(txValid), 32'h0);
    check("reset tx_data", 32'(txData), 32'h0);
    check("reset rx_ready", 32'(rxReady), 32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle();
    addr = A_STATUS;

    for (int i = 0; i < 33; i++) begin
      addr = tbl[i].addr; we = tbl[i].we; re = tbl[i].re; din = tbl[i].din;
      txReady = tbl[i].txRdy; rxValid = tbl[i].rxV; rxData = tbl[i].rxD;
      tick();
      check($sformatf("vec%0d dout", i), dout, tbl[i].expDout);
    end
    idle();

    // RX empty + CPU pop + UART push on one edge.
    addr = A_RX; re = 1'b1; rxValid = 1'b1; rxData = 8'h3C;
    tick();
    check("rx empty pop+push dout", dout, 32'h0);
    idle();
    cpuRead(A_STATUS);
    check("rx empty pop+push status", dout, 32'h0000_010B);
    cpuRead(A_RX);
    check("rx empty pop+push byte", dout, 32'h0000_003C);

    // RX overflow, including a CPU pop while full and a byte arrives.
    rxValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rxData = 8'h10 + 8'(i);
      tick();
    end
    check("rx full ready", 32'(rxReady), 32'h0);
    rxData = 8'hEE; addr = A_RX; re = 1'b1;
    tick();
    check("rx full pop dout", dout, 32'h0000_0010);
    check("rx full pop ready back", 32'(rxReady), 32'h1);
    check("ovf irq not yet", 32'(irq), 32'h0);
    idle();
    tick();
    check("ovf irq raised", 32'(irq), 32'h1);
    cpuRead(A_STATUS);
    check("ovf status", dout, 32'h0000_070F);
    cpuWrite(A_STATUS, 32'h4, 4'hF);
    check("ovf clear irq lag", 32'(irq), 32'h1);
    tick();
    check("ovf clear irq low", 32'(irq), 32'h0);
    for (int i = 1; i < 8; i++) begin
      cpuRead(A_RX);
      check($sformatf("rx drain %0d", i), dout, 32'h10 + 32'(i));
    end

    // TX full + CPU push + UART pop on one edge.
    for (int i = 0; i < 8; i++) cpuWrite(A_TX, 32'h60 + 32'(i), 4'h1);
    addr = A_TX; din = 32'h99; we = 4'h1; txReady = 1'b1;
    tick();
    idle();
    cpuRead(A_STATUS);
    check("tx full push+pop status", dout, 32'h0008_0000);
    for (int i = 0; i < 7; i++) expTx[i] = 8'h61 + 8'(i);
    expTx[7] = 8'h99;
    txReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tx order %0d", i), 32'(txData), 32'(expTx[i]));
      tick();
    end
    idle();

    // Stall masks writes and reads; unstalled IRQ_EN write raises irq a cycle later.
    stall = 1'b1; addr = A_IE; we = 4'h1; din = 32'h2;
    tick();
    we = 4'h0; re = 1'b1; addr = A_STATUS;
    tick();
    idle();
    cpuRead(A_IE);
    check("stalled ie write", dout, 32'h0);
    check("stalled irq", 32'(irq), 32'h0);
    cpuWrite(A_IE, 32'h2, 4'h1);
    check("tx_ie irq lag", 32'(irq), 32'h0);
    tick();
    check("tx_ie irq", 32'(irq), 32'h1);
    cpuWrite(A_IE, 32'h0, 4'h1);
    tick();

    // Reset in the middle of a burst.
    for (int i = 0; i < 3; i++) cpuWrite(A_TX, 32'hC0 + 32'(i), 4'h1);
    rxValid = 1'b1; rxData = 8'h77;
    tick();
    idle();
    rst = 1'b0;
    #1;
    modelReset();
    check("midreset tx_valid", 32'(txValid), 32'h0);
    check("midreset rx_ready", 32'(rxReady), 32'h1);
    check("midreset dout", dout, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cpuRead(A_STATUS);
    check("midreset status", dout, 32'h0000_0009);

    // Randomized traffic; bias alternates so both FIFOs hit full and empty.
    for (int n = 0; n < 3000; n++) begin
      logic fillPhase;
      fillPhase = ((n / 300) % 2) == 0;
      stall   = ($urandom_range(0, 7) == 0);
      addr    = ($urandom_range(0, 7) == 0) ? 32'($urandom) : (BASE | 32'($urandom_range(0, 15)));
      we      = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      re      = ($urandom_range(0, 2) == 0);
      din     = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
      txReady = fillPhase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rxValid = fillPhase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rxData  = 8'($urandom);
      tick();
    end
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
